// File: rtl/pipelined_popcount.sv
// Pipelined population count: 6-bit LUT chunks followed by a registered adder tree.
// Define POPCOUNT_ACC_EN to add a saturating per-frame accumulator stage after the tree.
module pipelined_popcount #(
    parameter int DIN_WIDTH = 64,
    parameter int ACC_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DIN_WIDTH-1:0] i_din,
    input  logic                 i_in_last,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [ACC_WIDTH-1:0] o_dout
);

    localparam int NCHUNK    = (DIN_WIDTH + 5) / 6;
    localparam int LEVELS    = $clog2(NCHUNK);
    localparam int CNT_WIDTH = $clog2(DIN_WIDTH + 1);

    function automatic logic [63:0][2:0] build_pop6_table();
        logic [63:0][2:0] t;
        int c;
        t = '0;
        for (int v = 0; v < 64; v++) begin
            c = 0;
            for (int b = 0; b < 6; b++) c += (v >> b) & 1;
            t[v] = 3'(c);
        end
        return t;
    endfunction

    function automatic int level_count(int l);
        return (NCHUNK + (1 << l) - 1) >> l;
    endfunction

    // Each tree level needs one more bit than the last, never more than the full count.
    function automatic int level_width(int l);
        return (3 + l < CNT_WIDTH) ? 3 + l : CNT_WIDTH;
    endfunction

    localparam logic [63:0][2:0] POP6 = build_pop6_table();
    localparam int TW = level_width(LEVELS);

    logic                  w_adv;
    logic [NCHUNK*6-1:0]   w_din_pad;
    logic [LEVELS:0]       r_vld;
    logic [TW-1:0]         w_tree_cnt;

    assign w_adv      = !o_out_valid || i_out_ready;
    assign o_in_ready = w_adv;
    assign w_din_pad  = (NCHUNK*6)'(i_din);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else if (w_adv) begin
            r_vld <= (LEVELS+1)'({r_vld, i_in_valid});
        end
    end

    genvar l, j;
    for (l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = level_count(l);
        localparam int W = level_width(l);
        logic [W-1:0] r_sum  [N];
        logic [W-1:0] w_next [N];

        if (l == 0) begin : g_leaf
            for (j = 0; j < N; j++) begin : g_chunk
                assign w_next[j] = W'(POP6[w_din_pad[6*j +: 6]]);
            end
        end else begin : g_node
            localparam int NP = level_count(l - 1);
            for (j = 0; j < N; j++) begin : g_pair
                if (2*j + 1 < NP) begin : g_add
                    assign w_next[j] = W'(g_lvl[l-1].r_sum[2*j]) + W'(g_lvl[l-1].r_sum[2*j+1]);
                end else begin : g_pass
                    assign w_next[j] = W'(g_lvl[l-1].r_sum[2*j]);
                end
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int k = 0; k < N; k++) r_sum[k] <= '0;
            end else if (w_adv) begin
                for (int k = 0; k < N; k++) r_sum[k] <= w_next[k];
            end
        end
    end

    assign w_tree_cnt = g_lvl[LEVELS].r_sum[0];

`ifdef POPCOUNT_ACC_EN
    logic [LEVELS:0]      r_last;
    logic                 r_out_vld;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_dout;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_sum_sat;

    assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH+1)'(w_tree_cnt);
    assign w_sum_sat = w_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last    <= '0;
            r_out_vld <= 1'b0;
            r_acc     <= '0;
            r_dout    <= '0;
        end else if (w_adv) begin
            r_last    <= (LEVELS+1)'({r_last, i_in_last});
            r_out_vld <= r_vld[LEVELS] && r_last[LEVELS];
            if (r_vld[LEVELS]) begin
                // Emitting a frame result also starts the next frame from zero.
                if (r_last[LEVELS]) begin
                    r_dout <= w_sum_sat;
                    r_acc  <= '0;
                end else begin
                    r_acc  <= w_sum_sat;
                end
            end
        end
    end

    assign o_out_valid = r_out_vld;
    assign o_dout      = r_dout;
`else
    logic w_unused_last;

    assign w_unused_last = i_in_last;
    assign o_out_valid   = r_vld[LEVELS];
    assign o_dout        = ACC_WIDTH'(w_tree_cnt);
`endif

endmodule

// File: tb/tb_pipelined_popcount.sv
// Scoreboard bench for pipelined_popcount: 64-bit main instance (plus a 7-bit dout copy)
// and 13-bit / 6-bit side instances, checked against a $countones reference model.
module tb_pipelined_popcount;

`ifdef POPCOUNT_ACC_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    localparam int LAT64 = 5 + XL;
    localparam int LAT13 = 3 + XL;
    localparam int LAT6  = 1 + XL;

    typedef struct {
        longint exp_a;
        longint exp_b;
        int     cyc;
        bit     lat;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic [63:0] din = '0;
    logic        in_ready, out_valid, in_ready_s, out_valid_s;
    logic [31:0] dout;
    logic [6:0]  dout_s;
    logic        v13 = 1'b0, rdy13, ov13;
    logic [12:0] d13 = '0;
    logic [7:0]  dout13;
    logic        v6 = 1'b0, rdy6, ov6;
    logic [5:0]  d6 = '0;
    logic [3:0]  dout6;

    ent_t   q[$], q13[$], q6[$];
    int     n_cmp = 0, n_bad = 0;
    int     cyc = 0;
    longint m_sum = 0;
    bit     lat_phase = 1'b0, go = 1'b0, aux_run = 1'b1;
    bit     prev_stall = 1'b0;
    logic [31:0] prev_dout = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_popcount #(.DIN_WIDTH(64), .ACC_WIDTH(32)) u_dut (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .i_din(din), .i_in_last(in_last), .o_out_valid(out_valid),
        .i_out_ready(out_ready), .o_dout(dout));

    pipelined_popcount #(.DIN_WIDTH(64), .ACC_WIDTH(7)) u_dut_sat (
        .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready_s),
        .i_din(din), .i_in_last(in_last), .o_out_valid(out_valid_s),
        .i_out_ready(out_ready), .o_dout(dout_s));

    pipelined_popcount #(.DIN_WIDTH(13), .ACC_WIDTH(8)) u_dut13 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v13), .o_in_ready(rdy13),
        .i_din(d13), .i_in_last(1'b1), .o_out_valid(ov13),
        .i_out_ready(1'b1), .o_dout(dout13));

    pipelined_popcount #(.DIN_WIDTH(6), .ACC_WIDTH(4)) u_dut6 (
        .i_clk(clk), .i_rst(rst), .i_in_valid(v6), .o_in_ready(rdy6),
        .i_din(d6), .i_in_last(1'b1), .o_out_valid(ov6),
        .i_out_ready(1'b1), .o_dout(dout6));

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint sat_to(input longint v, input int bits);
        longint mx;
        mx = (longint'(1) << bits) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic spurious(input string name, input longint act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got output %0d expected none pending (cycle %0d)", name, act, cyc);
    endtask

    // Main monitor and reference model: outputs popped first, then the beat accepted at
    // the coming edge is pushed.
    always @(negedge clk) begin
        ent_t   e;
        longint c;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                spurious("spurious_out", dout);
            end else begin
                e = q.pop_front();
                chk("dout", dout, e.exp_a);
                chk("dout_acc7", dout_s, e.exp_b);
                if (e.lat) chk("latency", cyc - e.cyc, LAT64);
            end
        end
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_dout", dout, prev_dout);
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (!out_valid) chk("idle_in_ready", in_ready, 1);
        end
        prev_stall = out_valid && !out_ready && !rst;
        prev_dout  = dout;
        if (rst) begin
            q.delete();
            m_sum = 0;
        end else if (in_valid && in_ready) begin
            c = longint'($countones(din));
`ifdef POPCOUNT_ACC_EN
            m_sum += c;
            if (in_last) begin
                q.push_back('{sat_to(m_sum, 32), sat_to(m_sum, 7), cyc, lat_phase});
                m_sum = 0;
            end
`else
            q.push_back('{c, c, cyc, lat_phase});
`endif
        end
    end

    always @(negedge clk) begin
        ent_t e;
        if (ov13) begin
            if (q13.size() == 0) spurious("spurious_w13", dout13);
            else begin
                e = q13.pop_front();
                chk("dout_w13", dout13, e.exp_a);
                chk("latency_w13", cyc - e.cyc, LAT13);
            end
        end
        if (rst) q13.delete();
        else if (v13 && rdy13) q13.push_back('{longint'($countones(d13)), 0, cyc, 1'b1});
    end

    always @(negedge clk) begin
        ent_t e;
        if (ov6) begin
            if (q6.size() == 0) spurious("spurious_w6", dout6);
            else begin
                e = q6.pop_front();
                chk("dout_w6", dout6, e.exp_a);
                chk("latency_w6", cyc - e.cyc, LAT6);
            end
        end
        if (rst) q6.delete();
        else if (v6 && rdy6) q6.push_back('{longint'($countones(d6)), 0, cyc, 1'b1});
    end

    task automatic send(input logic [63:0] d, input logic l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        din      = d;
        in_last  = l;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            done = in_ready && !rst;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
        end
        in_valid = 1'b0;
    endtask

    initial begin
        for (int t = 0; t < 20000 && !go; t++) @(posedge clk);
        #1;
        for (int t = 0; aux_run && t < 5000; t++) begin
            v13 = 1'b1;
            v6  = 1'b1;
            d13 = (t == 0) ? 13'h1FFF : (t == 1) ? 13'h1000 : 13'($urandom);
            d6  = 6'(t);
            @(posedge clk);
            #1;
        end
        v13 = 1'b0;
        v6  = 1'b0;
    end

    initial begin
        int sent;
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_dout", dout, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_dout_acc7", dout_s, 0);
        chk("reset_valid_w13", ov13, 0);
        chk("reset_valid_w6", ov6, 0);
        @(posedge clk);
        #1;
        go = 1'b1;

        lat_phase = 1'b1;
        send(64'h0, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        send(64'h8000_0000_0000_0001, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'h0F, 1'b0);
        send(64'h01, 1'b1);
        send(64'h03, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        lat_phase = 1'b0;

        // Eight beats with a three-cycle consumer stall in the middle of the stream.
        sent = 0;
        din  = {$urandom, $urandom};
        for (int t = 0; t < 60 && sent < 8; t++) begin
            in_valid  = 1'b1;
            in_last   = sent[0];
            out_ready = !(t >= 6 && t <= 8);
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) begin
                sent++;
                din = {$urandom, $urandom};
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_beats_sent", sent, 8);
        repeat (12) @(posedge clk);
        #1;

        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            in_last   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       din = 64'h0;
                1:       din = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       din = 64'h1 << $urandom_range(0, 63);
                default: din = {$urandom, $urandom};
            endcase
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset mid-frame: in-flight beats and the partial accumulation are dropped.
        send({$urandom, $urandom}, 1'b0);
        send({$urandom, $urandom}, 1'b0);
        in_valid = 1'b1;
        din      = 64'hFFFF_FFFF_FFFF_FFFF;
        in_last  = 1'b1;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        send(64'h1, 1'b1);

        aux_run = 1'b0;
        for (int t = 0; t < 40 && (q.size() != 0 || q13.size() != 0 || q6.size() != 0); t++)
            @(posedge clk);
        @(negedge clk);
        chk("drain_main", q.size(), 0);
        chk("drain_w13", q13.size(), 0);
        chk("drain_w6", q6.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipelined_popcount.md
# pipelined_popcount

Registered, pipelined population count for wide vectors. The block splits the input into 6-bit chunks, counts each chunk with a LUT6-sized table, and sums the chunk counts through a registered adder tree. Valid/ready handshakes on both sides let it sit in streaming datapaths between a producer and a consumer. An optional compile-time accumulator adds per-beat counts across a multi-beat frame.

## Interface
- DIN_WIDTH, 64, input vector width, ≥1.
- ACC_WIDTH, 32, width of `dout`. Must be ≥ clog2(DIN_WIDTH+1).
- Derived: NCHUNK = ceil(DIN_WIDTH/6); LEVELS = clog2(NCHUNK) (0 when NCHUNK=1); CNT_WIDTH = clog2(DIN_WIDTH+1).
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- din  in  DIN_WIDTH  vector to count.
- in_last  in  1  last beat of a frame. Used only with POPCOUNT_ACC_EN; ignored otherwise.
- out_valid  out  1  `dout` valid.
- out_ready  in  1  consumer accepts `dout`.
- dout  out  ACC_WIDTH  count, zero-extended.

## Operation
- Chunking: chunk k = din[6k+5:6k]. The top chunk is zero-padded when DIN_WIDTH%6≠0. Each chunk maps through a 64-entry constant table to a 3-bit count.
- Stage 0 registers the NCHUNK 3-bit counts.
- Tree stages 1..LEVELS each register pairwise sums. An odd element passes through zero-extended. Each level widens by 1 bit, capped at CNT_WIDTH.
- A valid bit travels with every stage. Bubbles occupy slots and are not compacted.
- Global enable: adv = !out_valid || out_ready. All stage registers, including valid bits, load only when adv=1. in_ready = adv.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- `dout` and `out_valid` are driven directly from the final register. `dout` holds stable while out_valid && !out_ready.
- Arithmetic is exact. Without the accumulator, the count never overflows CNT_WIDTH.

## Timing
- Reset: all valid bits 0, all data registers 0. So out_valid=0, dout=0, in_ready=1 the cycle after rst is sampled high.
- Reset mid-operation drops all in-flight beats and clears the accumulator. Beats presented while rst=1 are discarded.
- Latency without the accumulator: LATENCY = 1 + LEVELS cycles from acceptance to out_valid, when out_ready stays high. For DIN_WIDTH=64: NCHUNK=11, LEVELS=4, LATENCY=5.
- Throughput is one beat per cycle while out_ready=1.
- When out_ready=0 and out_valid=1, the whole pipeline freezes and in_ready=0 in the same cycle. There is no skid buffer, so in_ready depends combinationally on out_ready.
- Simultaneous consume and accept in one cycle is legal and required for full throughput.

## Configuration
- Macro: POPCOUNT_ACC_EN.
- Defined: one extra register stage after the tree, so LATENCY = 2 + LEVELS.
  - `in_last` travels with each beat.
  - An internal ACC_WIDTH accumulator adds each valid beat's count. It saturates at 2^ACC_WIDTH−1 and never wraps.
  - out_valid asserts only for the beat tagged last. dout = accumulator + that beat's count, saturated.
  - The accumulator clears to 0 in the same advance that emits the frame result, so the next beat starts a new frame.
  - A single beat with in_last=1 emits its own count.
- Undefined: no accumulator, and `in_last` is ignored. Every accepted beat produces one output, with dout = zero-extended CNT_WIDTH count.

## Test plan
- Reset/basic (DIN_WIDTH=64, no macro): after rst, send din=64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001 back-to-back with out_ready=1. Expect dout=0, 64, 2 on consecutive cycles, the first out_valid 5 cycles after the first accept.
- Backpressure: stream 8 random beats, hold out_ready=0 for 3 cycles mid-stream. Expect dout stable during the stall, in_ready=0 throughout, and no loss or duplication of results versus a reference model.
- Padding (DIN_WIDTH=13): din=13'h1FFF gives 13; din=13'h1000 gives 1. Latency is 1+clog2(3)=3.
- Single chunk (DIN_WIDTH=6): 64 exhaustive values. Each result equals its bit count with latency 1.
- Accumulate (POPCOUNT_ACC_EN, DIN_WIDTH=64): frame of 3 beats (FF..FF, 0F, last=1 with 01) gives one output 69. The following single-beat frame with 03 gives 2.
- Saturation/reset (POPCOUNT_ACC_EN, ACC_WIDTH=7): 3 beats of all-ones with the last flagged gives 127. Asserting rst after 2 beats of a frame, then a last beat of 64'h1, gives 1.
